// File: rtl/tmu_result_writeback.sv
// tmu_result_writeback
// Drain end of the TMU output FIFO. Each popped word carries one texel for one lane; it is
// written into the SM register-file write port, and on the beat tagged last the scoreboard
// entry for the warp/destination register is released with the number of texels written.
//
// Word layout (LSB first): texel[TEXEL_W], lane[LANE_W], warp[WARP_W], reg[REG_W], last.
// Bit WIDTH-1 is parity; the remaining bits are reserved.
// Requires TEXEL_W+LANE_W+WARP_W+REG_W+2 <= WIDTH.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   fifo_valid_i/_data_i  FIFO read side, popped when fifo_ready_o is high
//   fifo_ready_o          pop strobe; a function of state, rf_ready_i and held last bit only
//   rf_we_o, rf_ready_i   register-file write handshake
//   rf_warp/reg/lane/data_o  write address and texel, stable while rf_ready_i is low
//   sb_release_o          one-cycle release pulse; sb_warp/reg/count_o valid with it
//   err_overrun_o         sticky: a beat arrived with the count already at 2^LANE_W
//   err_parity_o          sticky parity error
//
// Optional feature: define TMU_WB_PARITY_EN to check even parity (bit WIDTH-1 over
// bits [WIDTH-2:0]) when a word is captured. A bad beat is not written and not counted,
// but its last flag still triggers the release. Without the macro err_parity_o is 0.
//
// After reset every output is 0 except fifo_ready_o, which follows the IDLE state.
module tmu_result_writeback #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned TEXEL_W = 64,
    parameter int unsigned LANE_W  = 5,
    parameter int unsigned WARP_W  = 6,
    parameter int unsigned REG_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fifo_valid_i,
    input  logic [WIDTH-1:0]   fifo_data_i,
    output logic               fifo_ready_o,
    output logic               rf_we_o,
    input  logic               rf_ready_i,
    output logic [WARP_W-1:0]  rf_warp_o,
    output logic [REG_W-1:0]   rf_reg_o,
    output logic [LANE_W-1:0]  rf_lane_o,
    output logic [TEXEL_W-1:0] rf_data_o,
    output logic               sb_release_o,
    output logic [WARP_W-1:0]  sb_warp_o,
    output logic [REG_W-1:0]   sb_reg_o,
    output logic [LANE_W:0]    sb_count_o,
    output logic               err_overrun_o,
    output logic               err_parity_o
);

    localparam int unsigned LaneLo  = TEXEL_W;
    localparam int unsigned WarpLo  = LaneLo + LANE_W;
    localparam int unsigned RegLo   = WarpLo + WARP_W;
    localparam int unsigned LastBit = RegLo + REG_W;

    localparam logic [LANE_W:0] CountMax = {1'b1, {LANE_W{1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRelease
    } state_e;

    state_e               state_q, state_d;
    logic [TEXEL_W-1:0]   texel_q;
    logic [LANE_W-1:0]    lane_q;
    logic [WARP_W-1:0]    warp_q;
    logic [REG_W-1:0]     dreg_q;
    logic                 last_q;
    logic                 bad_q;
    logic [LANE_W:0]      count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 parity_err_q;
    logic                 capture;
    logic                 par_bad;

    // Reserved bits carry no meaning here.
    logic unused_reserved;
    assign unused_reserved = ^fifo_data_i[WIDTH-1:LastBit+1];

`ifdef TMU_WB_PARITY_EN
    // Even parity: the XOR of the whole word, parity bit included, must be 0.
    assign par_bad = ^fifo_data_i;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        capture      = 1'b0;
        fifo_ready_o = 1'b0;
        rf_we_o      = 1'b0;
        sb_release_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                fifo_ready_o = 1'b1;
                if (fifo_valid_i) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                rf_we_o = !bad_q;
                // A parity-bad beat still waits for rf_ready_i so the pop strobe stays a
                // function of state, rf_ready_i and the last bit alone.
                if (rf_ready_i) begin
                    if (!bad_q) begin
                        if (count_q == CountMax) begin
                            overrun_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (last_q) begin
                        state_d = StRelease;
                    end else begin
                        fifo_ready_o = 1'b1;
                        if (fifo_valid_i) begin
                            capture = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StRelease: begin
                sb_release_o = 1'b1;
                count_d      = '0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            texel_q      <= '0;
            lane_q       <= '0;
            warp_q       <= '0;
            dreg_q       <= '0;
            last_q       <= 1'b0;
            bad_q        <= 1'b0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_q | (capture & par_bad);
            if (capture) begin
                texel_q <= fifo_data_i[TEXEL_W-1:0];
                lane_q  <= fifo_data_i[LaneLo+:LANE_W];
                warp_q  <= fifo_data_i[WarpLo+:WARP_W];
                dreg_q  <= fifo_data_i[RegLo+:REG_W];
                last_q  <= fifo_data_i[LastBit];
                bad_q   <= par_bad;
            end
        end
    end

    assign rf_warp_o     = warp_q;
    assign rf_reg_o      = dreg_q;
    assign rf_lane_o     = lane_q;
    assign rf_data_o     = texel_q;

    // Release fields read 0 outside the pulse so reset and idle look identical.
    assign sb_warp_o     = (state_q == StRelease) ? warp_q  : '0;
    assign sb_reg_o      = (state_q == StRelease) ? dreg_q  : '0;
    assign sb_count_o    = (state_q == StRelease) ? count_q : '0;

    assign err_overrun_o = overrun_q;
    assign err_parity_o  = parity_err_q;

endmodule
